// File: rtl/spi_master_pkg.sv
// rtl/spi_master_pkg.sv - shared types and constants for the SPI master driver
package spi_master_pkg;

  typedef enum logic [1:0] {
    WR_ADDR = 2'b00,
    WR_DATA = 2'b01,
    RD_ADDR = 2'b10,
    RD_DATA = 2'b11
  } spi_op_e;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SEL,
    S_SHIFT,
    S_WAIT,
    S_RECV,
    S_GAP
  } state_e;

  localparam int FRAME_BITS = 10;
  localparam int RX_BITS    = 8;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/spi_master_shifter.sv
// rtl/spi_master_shifter.sv - TX/RX shift registers and the shared phase counter
module spi_master_shifter
  import spi_master_pkg::*;
#(
  parameter int CNT_W = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  load_i,
  input  logic [FRAME_BITS-1:0] load_data_i,
  input  logic                  tx_shift_i,
  input  logic                  rx_shift_i,
  input  logic                  cnt_clr_i,
  input  logic                  miso_i,
  output logic                  tx_bit_o,
  output logic [RX_BITS-1:0]    rx_next_o,
  output logic [CNT_W-1:0]      cnt_o
);

  logic [FRAME_BITS-1:0] tx_q;
  // Only seven bits are stored: the eighth arrives on MISO at the capture edge.
  logic [RX_BITS-2:0]    rx_q;
  logic [CNT_W-1:0]      cnt_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      tx_q  <= '0;
      rx_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (load_i) begin
        tx_q <= load_data_i;
      end else if (tx_shift_i) begin
        tx_q <= {tx_q[FRAME_BITS-2:0], 1'b0};
      end
      if (rx_shift_i) begin
        rx_q <= rx_next_o[RX_BITS-2:0];
      end
      cnt_q <= cnt_clr_i ? '0 : cnt_q + CNT_W'(1);
    end
  end

  assign tx_bit_o  = tx_q[FRAME_BITS-1];
  assign rx_next_o = {rx_q, miso_i};
  assign cnt_o     = cnt_q;

endmodule

// File: rtl/spi_master_driver.sv
// rtl/spi_master_driver.sv - command-driven SPI master, one bit per clk, frame FSM
module spi_master_driver
  import spi_master_pkg::*;
#(
  parameter int RD_WAIT = 2,
  parameter int GAP     = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [1:0] cmd_op,
  input  logic [7:0] cmd_data,
  output logic       rsp_valid,
  output logic [7:0] rsp_data,
  output logic       busy,
  output logic       SS_n,
  output logic       MOSI,
  input  logic       MISO
);

  localparam int CNT_MAX = max_int(max_int(FRAME_BITS, RX_BITS), max_int(RD_WAIT, GAP));
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam logic [CNT_W-1:0] SHIFT_LAST = CNT_W'(FRAME_BITS - 1);
  localparam logic [CNT_W-1:0] WAIT_LAST  = CNT_W'((RD_WAIT > 0) ? RD_WAIT - 1 : 0);
  localparam logic [CNT_W-1:0] RECV_LAST  = CNT_W'(RX_BITS - 1);
  localparam logic [CNT_W-1:0] GAP_LAST   = CNT_W'(GAP - 1);

  state_e             state_q, state_d;
  logic               ready_en_q;
  logic               rd_data_q;
  logic               rsp_valid_q;
  logic [RX_BITS-1:0] rsp_data_q;

  logic               load, tx_shift, rx_shift, capture, cnt_clr;
  logic               tx_bit;
  logic [RX_BITS-1:0] rx_next;
  logic [CNT_W-1:0]   cnt;

  spi_master_shifter #(.CNT_W(CNT_W)) u_shifter (
    .clk        (clk),
    .rst_n      (rst_n),
    .load_i     (load),
    .load_data_i({cmd_op, cmd_data}),
    .tx_shift_i (tx_shift),
    .rx_shift_i (rx_shift),
    .cnt_clr_i  (cnt_clr),
    .miso_i     (MISO),
    .tx_bit_o   (tx_bit),
    .rx_next_o  (rx_next),
    .cnt_o      (cnt)
  );

  always_comb begin
    state_d  = state_q;
    load     = 1'b0;
    tx_shift = 1'b0;
    rx_shift = 1'b0;
    capture  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (cmd_valid && ready_en_q) begin
          load    = 1'b1;
          state_d = S_SEL;
        end
      end
      S_SEL:   state_d = S_SHIFT;
      S_SHIFT: begin
        tx_shift = 1'b1;
        if (cnt == SHIFT_LAST) begin
          if (!rd_data_q)        state_d = S_GAP;
          else if (RD_WAIT == 0) state_d = S_RECV;
          else                   state_d = S_WAIT;
        end
      end
      S_WAIT: if (cnt == WAIT_LAST) state_d = S_RECV;
      S_RECV: begin
        rx_shift = 1'b1;
        if (cnt == RECV_LAST) begin
          capture = 1'b1;
          state_d = S_GAP;
        end
      end
      S_GAP:   if (cnt == GAP_LAST) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Every phase counts from zero, so the counter restarts on any state change.
  assign cnt_clr = (state_d != state_q);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      ready_en_q  <= 1'b0;
      rd_data_q   <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      ready_en_q  <= 1'b1;
      rsp_valid_q <= capture;
      if (load)    rd_data_q  <= (spi_op_e'(cmd_op) == RD_DATA);
      if (capture) rsp_data_q <= rx_next;
    end
  end

  assign cmd_ready = (state_q == S_IDLE) && ready_en_q;
  assign busy      = (state_q != S_IDLE);
  assign SS_n      = (state_q == S_IDLE) || (state_q == S_GAP);
  assign MOSI      = ((state_q == S_SEL) || (state_q == S_SHIFT)) ? tx_bit : 1'b0;
  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = rsp_data_q;

endmodule

// File: tb/tb_spi_master_driver.sv
// tb/tb_spi_master_driver.sv - self-checking bench with a RAM-style SPI slave model
module tb_spi_master_driver;

  localparam int RD_WAIT = 2;
  localparam int GAP     = 1;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       cmd_valid = 1'b0;
  logic [1:0] cmd_op = 2'b00;
  logic [7:0] cmd_data = 8'h00;
  logic       MISO = 1'b0;
  logic       cmd_ready, rsp_valid, busy, SS_n, MOSI;
  logic [7:0] rsp_data;

  always #5 clk = ~clk;

  spi_master_driver #(.RD_WAIT(RD_WAIT), .GAP(GAP)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .cmd_valid(cmd_valid),
    .cmd_ready(cmd_ready),
    .cmd_op   (cmd_op),
    .cmd_data (cmd_data),
    .rsp_valid(rsp_valid),
    .rsp_data (rsp_data),
    .busy     (busy),
    .SS_n     (SS_n),
    .MOSI     (MOSI),
    .MISO     (MISO)
  );

  typedef struct {
    logic [10:0] bits;
    int          len;
    int          gap;
    logic        tail;
  } frame_t;

  frame_t     frames[$];
  logic [7:0] rsps[$];
  int         checks = 0;
  int         errors = 0;
  int         hs = 0;

  // Slave device: a 256-byte RAM addressed by WR_ADDR/RD_ADDR frames.
  logic [7:0]  slave_mem[256];
  logic [7:0]  slave_addr = 8'h00;
  logic [7:0]  slave_rd = 8'h00;
  bit          in_frame = 1'b0;
  int          n = 0;
  int          hi = 0;
  int          fgap = 0;
  logic [10:0] bits = '0;
  logic        tail = 1'b0;

  // Independent expectation of what the RAM holds, driven by the issued commands.
  logic [7:0] model_mem[256];
  logic [7:0] model_addr = 8'h00;
  logic [7:0] last_rsp = 8'h00;

  always @(posedge clk) begin
    if (rst_n && cmd_valid && cmd_ready) hs++;
  end

  always @(negedge clk) begin
    if (!rst_n) begin
      in_frame = 1'b0;
      hi = 0;
      MISO = 1'b0;
    end else begin
      if (rsp_valid) rsps.push_back(rsp_data);
      if (!SS_n) begin
        if (!in_frame) begin
          in_frame = 1'b1;
          n = 0;
          bits = '0;
          tail = 1'b0;
          fgap = hi;
        end
        if (n < 11) bits = {bits[9:0], MOSI};
        else        tail = tail | MOSI;
        if (n == 10) begin
          case (bits[9:8])
            2'b00, 2'b10: slave_addr = bits[7:0];
            2'b01:        slave_mem[slave_addr] = bits[7:0];
            default:      slave_rd = slave_mem[slave_addr];
          endcase
        end
        if (n >= 11 + RD_WAIT && n <= 18 + RD_WAIT && bits[9:8] == 2'b11)
          MISO = slave_rd[7 - (n - 11 - RD_WAIT)];
        else
          MISO = 1'b0;
        n++;
      end else begin
        if (in_frame) begin
          frames.push_back('{bits, n, fgap, tail});
          in_frame = 1'b0;
          hi = 0;
        end
        hi++;
        MISO = 1'b0;
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Issue one command from a negedge and check the whole frame it produces.
  task automatic run(input logic [1:0] op, input logic [7:0] data, input bit keep, input bit chk_gap);
    int         wait_n = 0;
    int         busy_n = 0;
    int         exp_len;
    logic [7:0] exp_rsp = 8'h00;
    frame_t     f = '{11'h7ff, -1, -1, 1'bx};
    cmd_op = op;
    cmd_data = data;
    cmd_valid = 1'b1;
    while (!cmd_ready && wait_n < 200) begin
      @(negedge clk);
      wait_n++;
    end
    chk("accept_timeout", wait_n < 200, 1);
    @(negedge clk);
    if (!keep) cmd_valid = 1'b0;
    while (busy && busy_n < 100) begin
      busy_n++;
      @(negedge clk);
    end
    exp_len = (op == 2'b11) ? 19 + RD_WAIT : 11;
    case (op)
      2'b00, 2'b10: model_addr = data;
      2'b01:        model_mem[model_addr] = data;
      default: begin
        exp_rsp = model_mem[model_addr];
        last_rsp = exp_rsp;
      end
    endcase
    chk("busy_len", busy_n, exp_len + GAP);
    chk("frame_count", frames.size(), 1);
    if (frames.size() > 0) f = frames.pop_front();
    chk("frame_bits", f.bits, {op[1], op, data});
    chk("frame_len", f.len, exp_len);
    chk("mosi_tail", f.tail, 0);
    if (chk_gap) chk("gap_min", f.gap >= GAP + 1, 1);
    chk("rsp_count", rsps.size(), (op == 2'b11) ? 1 : 0);
    if (op == 2'b11 && rsps.size() > 0) chk("rsp_data_pulse", rsps.pop_front(), exp_rsp);
    rsps.delete();
    chk("rsp_hold", rsp_data, last_rsp);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    int wait_n;
    int hs0;
    logic [1:0] rop;
    logic [7:0] rdat;
    for (int i = 0; i < 256; i++) begin
      slave_mem[i] = 8'h00;
      model_mem[i] = 8'h00;
    end

    repeat (3) @(negedge clk);
    chk("rst_ss_n", SS_n, 1);
    chk("rst_mosi", MOSI, 0);
    chk("rst_cmd_ready", cmd_ready, 0);
    chk("rst_busy", busy, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_rsp_data", rsp_data, 8'h00);
    rst_n = 1'b1;
    @(negedge clk);
    chk("ready_after_rst", cmd_ready, 1);

    run(2'b00, 8'h3C, 1'b0, 1'b0);
    run(2'b01, 8'hA5, 1'b0, 1'b1);
    run(2'b10, 8'h3C, 1'b0, 1'b1);
    run(2'b11, 8'h00, 1'b0, 1'b1);
    chk("rd_a5", rsp_data, 8'hA5);

    hs0 = hs;
    run(2'b00, 8'h21, 1'b1, 1'b1);
    run(2'b01, 8'h77, 1'b1, 1'b1);
    run(2'b11, 8'h00, 1'b0, 1'b1);
    chk("stream_handshakes", hs - hs0, 3);

    cmd_op = 2'b01;
    cmd_data = 8'hA5;
    cmd_valid = 1'b1;
    wait_n = 0;
    while (!cmd_ready && wait_n < 200) begin
      @(negedge clk);
      wait_n++;
    end
    @(negedge clk);
    cmd_valid = 1'b0;
    repeat (5) @(negedge clk);
    chk("pre_rst_busy", busy, 1);
    rst_n = 1'b0;
    @(negedge clk);
    chk("midrst_ss_n", SS_n, 1);
    chk("midrst_mosi", MOSI, 0);
    chk("midrst_busy", busy, 0);
    chk("midrst_ready", cmd_ready, 0);
    chk("midrst_rsp_valid", rsp_valid, 0);
    chk("midrst_rsp_data", rsp_data, 8'h00);
    last_rsp = 8'h00;
    frames.delete();
    rsps.delete();
    rst_n = 1'b1;
    @(negedge clk);
    chk("midrst_ready_after", cmd_ready, 1);
    run(2'b01, 8'hC3, 1'b0, 1'b0);

    run(2'b00, 8'h10, 1'b0, 1'b1);
    run(2'b01, 8'h5A, 1'b0, 1'b1);
    run(2'b10, 8'h10, 1'b0, 1'b1);
    run(2'b11, 8'h00, 1'b0, 1'b1);
    chk("e2e_5a", rsp_data, 8'h5A);

    for (int k = 0; k < 24; k++) begin
      rop = 2'($urandom_range(0, 3));
      rdat = 8'($urandom);
      if (rop[0] == 1'b0) rdat = 8'($urandom_range(0, 7));
      run(rop, rdat, 1'($urandom_range(0, 1)), 1'b1);
    end
    cmd_valid = 1'b0;
    repeat (4) @(negedge clk);
    chk("final_idle", busy, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
